// File: rtl/alu_result_checker_if.sv
// alu_result_checker_if
// Purpose: groups the stimulus/response signals seen on the consumer side of
// the 4-bit ALU so a checker can be attached with a single port.
// Signals:
//   in_valid  - R2/R3/select carry a stimulus this cycle
//   R2, R3    - ALU operands as driven to the ALU
//   select    - ALU opcode
//   R0        - ALU result
//   R0_carry  - ALU carry/borrow
// Modports:
//   master - stimulus side: drives the stimulus, observes the ALU result
//   slave  - checker side: observes everything
interface alu_result_checker_if #(
  parameter int size = 4,
  parameter int n    = 3
);
  logic            in_valid;
  logic [size-1:0] R2;
  logic [size-1:0] R3;
  logic [n-1:0]    select;
  logic [size-1:0] R0;
  logic            R0_carry;

  modport master (
    output in_valid, R2, R3, select,
    input  R0, R0_carry
  );

  modport slave (
    input in_valid, R2, R3, select, R0, R0_carry
  );
endinterface

// File: rtl/alu_result_checker.sv
// alu_result_checker
// Purpose: self-checking response monitor for the 4-bit ALU. Every stimulus
// accepted while running is turned into an expected {carry, R0} by a golden
// model, delayed by the ALU latency, and compared against the live ALU output.
// Results are held as a sticky error flag, saturating counters and a record of
// the first failure of the run.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - clears all results and enters RUN (from any state)
//   stop            - ends the run once the in-flight compares have drained
//   bus             - ALU stimulus/response bundle (slave side)
//   busy            - state is RUN or DRAIN
//   done            - state is DONE
//   error_flag      - sticky, set on any mismatch
//   chk_count       - number of comparisons made, saturating
//   err_count       - number of mismatches, saturating
//   first_sel       - opcode of the first failure
//   first_exp       - expected {carry, R0} of the first failure
//   first_got       - actual {carry, R0} of the first failure
module alu_result_checker #(
  parameter int size = 4,
  parameter int n    = 3,
  parameter int LAT  = 1,
  parameter int CW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  alu_result_checker_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error_flag,
  output logic [CW-1:0]        chk_count,
  output logic [CW-1:0]        err_count,
  output logic [n-1:0]         first_sel,
  output logic [size:0]        first_exp,
  output logic [size:0]        first_got
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state;
  state_t         state_next;

  logic [size:0]  exp_val;
  logic           capture;
  logic [LAT-1:0] pipe_valid;
  logic [n-1:0]   pipe_sel [LAT];
  logic [size:0]  pipe_exp [LAT];
  logic [size:0]  got_val;
  logic           cmp_now;
  logic           carry_checked;
  logic           mismatch;

  // Golden model, evaluated at size+1 bits so the top bit is the carry.
  // For SUB the top bit of the extended difference is exactly the borrow.
  always_comb begin
    exp_val = '0;
    case (bus.select)
      n'(0):   exp_val = {1'b0, bus.R2};
      n'(1):   exp_val = {1'b0, ~bus.R2};
      n'(2):   exp_val = {1'b0, bus.R2} + {1'b0, bus.R3};
      n'(3):   exp_val = {1'b0, bus.R2} - {1'b0, bus.R3};
      n'(4):   exp_val = {1'b0, bus.R2 | bus.R3};
      n'(5):   exp_val = {1'b0, bus.R2 & bus.R3};
      n'(6):   exp_val = {{size{1'b0}}, ($signed(bus.R2) < $signed(bus.R3))};
      default: exp_val = '0;
    endcase
  end

  // A start in the same cycle clears the delay line, so nothing is captured then.
  assign capture = (state == RUN) && bus.in_valid && !start;

  // Valid bits of the latency line; slot LAT-1 is the entry being compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
    end else if (start) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= capture;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Payload of the latency line; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    pipe_sel[0] <= bus.select;
    pipe_exp[0] <= exp_val;
    for (int i = 1; i < LAT; i++) begin
      pipe_sel[i] <= pipe_sel[i-1];
      pipe_exp[i] <= pipe_exp[i-1];
    end
  end

  // The carry output is only defined for ADD and SUB.
  assign got_val       = {bus.R0_carry, bus.R0};
  assign cmp_now       = pipe_valid[LAT-1];
  assign carry_checked = (pipe_sel[LAT-1] == n'(2)) || (pipe_sel[LAT-1] == n'(3));
  assign mismatch      = (got_val[size-1:0] != pipe_exp[LAT-1][size-1:0]) ||
                         (carry_checked && (got_val[size] != pipe_exp[LAT-1][size]));

  // Result bookkeeping. error_flag doubles as "first failure already recorded".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_flag <= 1'b0;
      chk_count  <= '0;
      err_count  <= '0;
      first_sel  <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else if (start) begin
      error_flag <= 1'b0;
      chk_count  <= '0;
      err_count  <= '0;
      first_sel  <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else if (cmp_now) begin
      if (chk_count != '1) begin
        chk_count <= chk_count + CW'(1);
      end
      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + CW'(1);
        end
        error_flag <= 1'b1;
        if (!error_flag) begin
          first_sel <= pipe_sel[LAT-1];
          first_exp <= pipe_exp[LAT-1];
          first_got <= got_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start overrides everything, including a simultaneous stop.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (stop) state_next = DRAIN;
        DRAIN:   if (pipe_valid == '0) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker
// Purpose: drives two checker instances (latency 1 / 8-bit counters and
// latency 3 / 3-bit counters) from behavioural ALU stubs with fault injection,
// and scores their result outputs against a reference model.
`timescale 1ns/1ps
module tb_alu_result_checker;

  localparam int LAT_A = 1;
  localparam int CW_A  = 8;
  localparam int LAT_B = 3;
  localparam int CW_B  = 3;

  typedef struct {
    int         due;
    logic [2:0] sel;
    logic [4:0] exp_v;
    logic [4:0] got_v;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;

  logic       busy_a, done_a, flag_a, busy_b, done_b, flag_b;
  logic [7:0] chk_a, err_a;
  logic [2:0] chk_b, err_b;
  logic [2:0] fsel_a, fsel_b;
  logic [4:0] fexp_a, fgot_a, fexp_b, fgot_b;

  logic fault_and [2];
  logic fault_inv [2];
  logic force_c   [2];
  logic running   [2];

  int   m_chk [2];
  int   m_err [2];
  int   m_max [2];
  logic       m_flag [2];
  logic [2:0] m_fsel [2];
  logic [4:0] m_fexp [2];
  logic [4:0] m_fgot [2];

  entry_t sb_a [$];
  entry_t sb_b [$];
  entry_t mon_e;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  alu_result_checker_if #(.size(4), .n(3)) bus_a ();
  alu_result_checker_if #(.size(4), .n(3)) bus_b ();

  alu_result_checker #(.size(4), .n(3), .LAT(LAT_A), .CW(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .error_flag(flag_a),
    .chk_count(chk_a), .err_count(err_a),
    .first_sel(fsel_a), .first_exp(fexp_a), .first_got(fgot_a)
  );

  alu_result_checker #(.size(4), .n(3), .LAT(LAT_B), .CW(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .error_flag(flag_b),
    .chk_count(chk_b), .err_count(err_b),
    .first_sel(fsel_b), .first_exp(fexp_b), .first_got(fgot_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU behaviour from the opcode table, using plain integers.
  function automatic logic [4:0] golden(int a, int b, int sel);
    int r;
    int c;
    int sa;
    int sb;
    r = 0;
    c = 0;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    case (sel)
      0: r = a;
      1: r = 15 - a;
      2: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      3: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      4: r = a | b;
      5: r = a & b;
      6: r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    return 5'(c * 16 + r);
  endfunction

  // What the ALU under observation produces, including injected faults.
  function automatic logic [4:0] alu_out(int a, int b, int sel, logic f_and, logic f_inv, logic f_c);
    logic [4:0] v;
    v = golden(a, b, sel);
    if (f_and && sel == 5) v[3:0] = 4'hF;
    if (f_inv) v[3:0] = ~v[3:0];
    if (f_c) v[4] = 1'b1;
    return v;
  endfunction

  // Behavioural ALU stubs with the latency each checker instance expects.
  logic [4:0] alu_pipe_a [LAT_A];
  logic [4:0] alu_pipe_b [LAT_B];

  always @(posedge clk) begin
    alu_pipe_a[0] <= alu_out(int'(bus_a.R2), int'(bus_a.R3), int'(bus_a.select),
                             fault_and[0], fault_inv[0], force_c[0]);
    for (int i = 1; i < LAT_A; i++) alu_pipe_a[i] <= alu_pipe_a[i-1];
  end

  always @(posedge clk) begin
    alu_pipe_b[0] <= alu_out(int'(bus_b.R2), int'(bus_b.R3), int'(bus_b.select),
                             fault_and[1], fault_inv[1], force_c[1]);
    for (int i = 1; i < LAT_B; i++) alu_pipe_b[i] <= alu_pipe_b[i-1];
  end

  assign bus_a.R0       = alu_pipe_a[LAT_A-1][3:0];
  assign bus_a.R0_carry = alu_pipe_a[LAT_A-1][4];
  assign bus_b.R0       = alu_pipe_b[LAT_B-1][3:0];
  assign bus_b.R0_carry = alu_pipe_b[LAT_B-1][4];

  task automatic check_value(string name, int got, int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_lane(int lane, string tag);
    if (lane == 0) begin
      check_value({tag, ".chk"},  int'(chk_a),  m_chk[0]);
      check_value({tag, ".err"},  int'(err_a),  m_err[0]);
      check_value({tag, ".flag"}, int'(flag_a), int'(m_flag[0]));
      check_value({tag, ".fsel"}, int'(fsel_a), int'(m_fsel[0]));
      check_value({tag, ".fexp"}, int'(fexp_a), int'(m_fexp[0]));
      check_value({tag, ".fgot"}, int'(fgot_a), int'(m_fgot[0]));
    end else begin
      check_value({tag, ".chk"},  int'(chk_b),  m_chk[1]);
      check_value({tag, ".err"},  int'(err_b),  m_err[1]);
      check_value({tag, ".flag"}, int'(flag_b), int'(m_flag[1]));
      check_value({tag, ".fsel"}, int'(fsel_b), int'(m_fsel[1]));
      check_value({tag, ".fexp"}, int'(fexp_b), int'(m_fexp[1]));
      check_value({tag, ".fgot"}, int'(fgot_b), int'(m_fgot[1]));
    end
  endtask

  // Apply one scored compare to the reference model.
  task automatic model_update(int lane, entry_t e);
    logic miss;
    miss = (e.got_v[3:0] != e.exp_v[3:0]) ||
           ((e.sel == 3'd2 || e.sel == 3'd3) && (e.got_v[4] != e.exp_v[4]));
    if (m_chk[lane] < m_max[lane]) m_chk[lane]++;
    if (miss) begin
      if (m_err[lane] < m_max[lane]) m_err[lane]++;
      if (!m_flag[lane]) begin
        m_fsel[lane] = e.sel;
        m_fexp[lane] = e.exp_v;
        m_fgot[lane] = e.got_v;
      end
      m_flag[lane] = 1'b1;
    end
  endtask

  task automatic flush_lane(int lane);
    if (lane == 0) sb_a.delete();
    else sb_b.delete();
    m_chk[lane]  = 0;
    m_err[lane]  = 0;
    m_flag[lane] = 1'b0;
    m_fsel[lane] = '0;
    m_fexp[lane] = '0;
    m_fgot[lane] = '0;
  endtask

  // Monitor: pops the expected compare in the cycle its result becomes visible.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_a.size() > 0 && sb_a[0].due == cyc) begin
        mon_e = sb_a.pop_front();
        model_update(0, mon_e);
        check_lane(0, "cmp_a");
      end
      if (sb_b.size() > 0 && sb_b[0].due == cyc) begin
        mon_e = sb_b.pop_front();
        model_update(1, mon_e);
        check_lane(1, "cmp_b");
      end
    end
  end

  task automatic apply_stimulus(int lane, int a, int b, int sel, bit valid, bit stp);
    entry_t e;
    if (lane == 0) begin
      bus_a.R2 = 4'(a); bus_a.R3 = 4'(b); bus_a.select = 3'(sel);
      bus_a.in_valid = valid; stop_a = stp;
    end else begin
      bus_b.R2 = 4'(a); bus_b.R3 = 4'(b); bus_b.select = 3'(sel);
      bus_b.in_valid = valid; stop_b = stp;
    end
    if (valid && running[lane]) begin
      e.due   = cyc + 1 + ((lane == 0) ? LAT_A : LAT_B);
      e.sel   = 3'(sel);
      e.exp_v = golden(a, b, sel);
      e.got_v = alu_out(a, b, sel, fault_and[lane], fault_inv[lane], force_c[lane]);
      if (lane == 0) sb_a.push_back(e);
      else sb_b.push_back(e);
    end
    @(posedge clk);
    #1;
    if (stp) running[lane] = 1'b0;
    if (lane == 0) begin bus_a.in_valid = 1'b0; stop_a = 1'b0; end
    else begin bus_b.in_valid = 1'b0; stop_b = 1'b0; end
  endtask

  task automatic idle(int lane, int cycles);
    for (int i = 0; i < cycles; i++) apply_stimulus(lane, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_start(int lane, bit with_stop);
    if (lane == 0) begin start_a = 1'b1; stop_a = with_stop; end
    else begin start_b = 1'b1; stop_b = with_stop; end
    @(posedge clk);
    #1;
    if (lane == 0) begin start_a = 1'b0; stop_a = 1'b0; end
    else begin start_b = 1'b0; stop_b = 1'b0; end
    flush_lane(lane);
    running[lane] = 1'b1;
  endtask

  task automatic random_burst(int lane, int count, bit with_faults);
    for (int i = 0; i < count; i++) begin
      if (with_faults) fault_inv[lane] = ($urandom_range(0, 7) == 0);
      apply_stimulus(lane, $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 7), ($urandom_range(0, 3) != 0), 1'b0);
    end
    fault_inv[lane] = 1'b0;
  endtask

  task automatic wait_done(int lane, int budget, string tag);
    int   waited;
    logic d;
    waited = 0;
    d = (lane == 0) ? done_a : done_b;
    while (!d && waited < budget) begin
      @(posedge clk);
      #1;
      waited++;
      d = (lane == 0) ? done_a : done_b;
    end
    check_value({tag, ".done"}, int'(d), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int l = 0; l < 2; l++) begin
      fault_and[l] = 1'b0;
      fault_inv[l] = 1'b0;
      force_c[l]   = 1'b0;
      running[l]   = 1'b0;
      flush_lane(l);
    end
    m_max[0] = (1 << CW_A) - 1;
    m_max[1] = (1 << CW_B) - 1;
    bus_a.in_valid = 1'b0; bus_a.R2 = '0; bus_a.R3 = '0; bus_a.select = '0;
    bus_b.in_valid = 1'b0; bus_b.R2 = '0; bus_b.R3 = '0; bus_b.select = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_lane(0, "reset_a");
    check_lane(1, "reset_b");
    check_value("reset.busy_a", int'(busy_a), 0);
    check_value("reset.done_a", int'(done_a), 0);
    check_value("reset.busy_b", int'(busy_b), 0);

    // Reset in the middle of a run aborts it and forgets in-flight stimuli.
    do_start(0, 1'b0);
    apply_stimulus(0, 3, 4, 2, 1'b1, 1'b0);
    apply_stimulus(0, 9, 9, 2, 1'b1, 1'b0);
    check_value("rst.pre_chk", int'(chk_a), 1);
    check_value("rst.pre_busy", int'(busy_a), 1);
    bus_a.R2 = 4'd7; bus_a.R3 = 4'd1; bus_a.select = 3'd2; bus_a.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    flush_lane(0);
    flush_lane(1);
    running[0] = 1'b0;
    running[1] = 1'b0;
    #1;
    check_lane(0, "rst.mid");
    check_value("rst.busy", int'(busy_a), 0);
    check_value("rst.done", int'(done_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(0, 7, 1, 2, 1'b1, 1'b0);
    idle(0, 3);
    check_value("rst.third_chk", int'(chk_a), 0);
    check_value("rst.idle_busy", int'(busy_a), 0);

    // Arithmetic pass cases, then random traffic.
    do_start(0, 1'b0);
    apply_stimulus(0, 15, 15, 2, 1'b1, 1'b0);
    apply_stimulus(0, 1, 15, 2, 1'b1, 1'b0);
    apply_stimulus(0, 15, 10, 3, 1'b1, 1'b0);
    apply_stimulus(0, 10, 15, 3, 1'b1, 1'b0);
    idle(0, 2);
    check_value("arith.chk", int'(chk_a), 4);
    check_value("arith.err", int'(err_a), 0);
    check_value("arith.flag", int'(flag_a), 0);
    random_burst(0, 40, 1'b1);

    // SLI signed boundaries, then drain to DONE.
    apply_stimulus(0, 15, 5, 6, 1'b1, 1'b0);
    apply_stimulus(0, 1, 15, 6, 1'b1, 1'b0);
    apply_stimulus(0, 0, 15, 6, 1'b1, 1'b0);
    apply_stimulus(0, 15, 0, 6, 1'b1, 1'b0);
    apply_stimulus(0, 8, 7, 6, 1'b1, 1'b0);
    apply_stimulus(0, 7, 7, 6, 1'b1, 1'b1);
    wait_done(0, 10, "drain_a");
    check_lane(0, "drain_a");

    // Injected AND fault; the second failure must not move first_*.
    do_start(0, 1'b0);
    fault_and[0] = 1'b1;
    apply_stimulus(0, 15, 10, 5, 1'b1, 1'b0);
    idle(0, 2);
    check_value("fault.err", int'(err_a), 1);
    check_value("fault.flag", int'(flag_a), 1);
    check_value("fault.fsel", int'(fsel_a), 5);
    check_value("fault.fexp", int'(fexp_a), 'h0A);
    check_value("fault.fgot", int'(fgot_a), 'h0F);
    apply_stimulus(0, 3, 6, 5, 1'b1, 1'b0);
    idle(0, 2);
    fault_and[0] = 1'b0;
    check_value("fault2.err", int'(err_a), 2);
    check_value("fault2.fsel", int'(fsel_a), 5);
    check_value("fault2.fexp", int'(fexp_a), 'h0A);
    check_value("fault2.fgot", int'(fgot_a), 'h0F);

    // Carry is ignored for OR but checked for ADD.
    do_start(0, 1'b0);
    force_c[0] = 1'b1;
    apply_stimulus(0, 5, 10, 4, 1'b1, 1'b0);
    idle(0, 2);
    check_value("cmask.chk", int'(chk_a), 1);
    check_value("cmask.err", int'(err_a), 0);
    apply_stimulus(0, 1, 1, 2, 1'b1, 1'b0);
    idle(0, 2);
    force_c[0] = 1'b0;
    check_value("cadd.err", int'(err_a), 1);

    // start and stop together: start wins and the run continues.
    do_start(0, 1'b1);
    idle(0, 2);
    check_value("startstop.busy", int'(busy_a), 1);
    check_value("startstop.done", int'(done_a), 0);
    apply_stimulus(0, 0, 0, 0, 1'b0, 1'b1);
    wait_done(0, 10, "startstop");

    // Latency 3 drain timing.
    do_start(1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1, i + 2, 3, i, 1'b1, 1'b0);
    apply_stimulus(1, 9, 4, 3, 1'b1, 1'b1);
    check_value("lat.busy0", int'(busy_b), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_value("lat.busy", int'(busy_b), 1);
      check_value("lat.notdone", int'(done_b), 0);
    end
    @(posedge clk);
    #1;
    check_value("lat.done", int'(done_b), 1);
    check_value("lat.busy_end", int'(busy_b), 0);
    check_value("lat.chk", int'(chk_b), 5);

    // Saturation of 3-bit counters.
    do_start(1, 1'b0);
    fault_inv[1] = 1'b1;
    for (int i = 0; i < 9; i++)
      apply_stimulus(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), 1'b1, 1'b0);
    fault_inv[1] = 1'b0;
    apply_stimulus(1, 0, 0, 0, 1'b0, 1'b1);
    wait_done(1, 10, "sat");
    check_value("sat.err", int'(err_b), 7);
    check_value("sat.chk", int'(chk_b), 7);

    // Random traffic with a restart while compares are in flight.
    do_start(1, 1'b0);
    random_burst(1, 12, 1'b1);
    do_start(1, 1'b0);
    random_burst(1, 20, 1'b1);
    apply_stimulus(1, 0, 0, 0, 1'b0, 1'b1);
    wait_done(1, 10, "rand_b");
    check_lane(1, "rand_b");

    check_value("sb_a.empty", sb_a.size(), 0);
    check_value("sb_b.empty", sb_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Self-checking response monitor for the 4-bit ALU `top`. It sits on the consumer side of the ALU's `R2`/`R3`/`select` → `R0`/`R0_carry` interface. Each accepted stimulus is captured and the expected result is computed from an internal golden model. The model is delayed by the ALU's pipeline latency and compared against the ALU's actual outputs. Results are kept as sticky error state, counters and a first-failure record, so a run can be judged in hardware without a simulator waveform check.

## Interface
- `size`, 4, operand/result width
- `n`, 3, opcode width
- `LAT`, 1, ALU latency in cycles, from stimulus sample to valid `R0`; legal range 1..4
- `CW`, 8, counter width

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; clears results and enters RUN
- `stop`  in  1  pulse; ends the run after the pipeline drains
- `in_valid`  in  1  `R2`/`R3`/`select` hold a stimulus to be checked this cycle
- `R2`, `R3`  in  `size`  ALU operands as driven to the ALU
- `select`  in  `n`  ALU opcode
- `R0`  in  `size`  ALU result
- `R0_carry`  in  1  ALU carry/borrow
- `busy`  out  1  state is RUN or DRAIN
- `done`  out  1  state is DONE
- `error_flag`  out  1  sticky; set on any mismatch
- `chk_count`  out  `CW`  number of comparisons made; saturating
- `err_count`  out  `CW`  number of mismatches; saturating
- `first_sel`  out  `n`  opcode of the first failure
- `first_exp`  out  `size`+1  expected value of the first failure, as {carry, R0}
- `first_got`  out  `size`+1  actual value of the first failure, as {carry, R0}

## Operation
- Golden model. All arithmetic is done at `size`+1 bits.
  - 0 MOV: R0=R2
  - 1 NOT: R0=~R2
  - 2 ADD: {c,R0}=R2+R3
  - 3 SUB: R0=R2−R3 mod 2^size; c=1 when R2<R3 unsigned (borrow)
  - 4 OR: R0=R2|R3
  - 5 AND: R0=R2&R3
  - 6 SLI: R0=1 if R2<R3 as signed two's complement, else 0
  - 7: R0=0
  - c=0 for every opcode except ADD and SUB.
- Compare rule:
  - R0 is compared for every opcode.
  - R0_carry is compared only for ADD and SUB.
- State machine:
  - IDLE: on `start` → RUN.
  - RUN: on `stop` → DRAIN. If `start` and `stop` are high in the same cycle, `start` wins: the run restarts and stays in RUN.
  - DRAIN: no new captures. Once all delay-line valid bits are 0 → DONE.
  - DONE: on `start` → RUN. All result outputs hold their values.
- Capture: when state is RUN and `in_valid`=1, push {valid, select, expected} into a `LAT`-deep shift register. When not capturing, push valid=0.
- Compare: when the entry leaving the delay line has valid=1, compare it against the live `R0`/`R0_carry` in that cycle.
  - `chk_count` increments.
  - On mismatch, `err_count` increments and `error_flag` is set.
  - On the first mismatch of a run, `first_*` are loaded and then frozen.
- `start` in any state performs the following:
  - clears `error_flag`, both counters, `first_*` and the delay line;
  - discards stimulus already in flight from the previous run;
  - enters RUN.
- Counters saturate at 2^CW−1 and do not wrap.

## Timing
- Reset (asynchronous, `rst_n`=0) sets:
  - state=IDLE;
  - every output to 0;
  - all delay-line valid bits to 0.
- Reset asserted mid-run aborts the run immediately. There is no partial DONE.
- A stimulus sampled at edge t is compared against the `R0` present in the cycle that ends at edge t+LAT. Counter, flag and `first_*` updates are visible after edge t+LAT.
- With back-to-back `in_valid`, the block accepts one stimulus per cycle with no stalls.
- `stop` in cycle t:
  - a stimulus with `in_valid` in the same cycle is still captured;
  - `busy` stays 1 until the last in-flight compare;
  - `done` rises on the edge after the last compare, or one cycle after entering DRAIN if nothing was in flight.
- `busy`=1 exactly when state is RUN or DRAIN. `done`=1 exactly when state is DONE.
- A single cycle can contain a compare from the previous run and a `start` at the same time. In that case the clear wins.

## Test plan
1. Reset mid-run. Set LAT=1, `start`, then send 3 ADD stimuli. Assert `rst_n`=0 during the second stimulus → all outputs read 0 and the state is IDLE. After reset release, the 3rd stimulus (if any) is not counted.
2. Arithmetic pass cases. Drive 15+15, 1+15, 15−10, 10−15 against a correct ALU:
   - expected pairs are {1,14}, {1,0}, {0,5}, {1,11};
   - required result: `chk_count`=4, `err_count`=0, `error_flag`=0.
3. SLI signed boundaries, all expected to pass. Operands in (R2,R3) order:
   - (15,5) → 1
   - (1,15) → 0
   - (0,15) → 0
   - (15,0) → 1
   - (8,7) → 1
   - (7,7) → 0
4. Injected fault. Force the ALU's AND result to 0xF and send AND(15,10):
   - `err_count`=1, `error_flag`=1;
   - `first_sel`=5, `first_exp`=0x0A, `first_got`=0x0F.
   - A second fault then leaves `first_*` unchanged.
5. Latency and drain. Set LAT=3 and send 5 back-to-back stimuli, with `stop` in the same cycle as the 5th:
   - `busy` stays high 3 more cycles;
   - `done` rises on the following edge;
   - `chk_count`=5.
6. Carry masking and saturation.
   - An OR with `R0_carry`=1 and a correct R0 counts no error.
   - With CW=3, 9 forced mismatches leave `err_count`=7 and `chk_count`=7.
